cmp4: RTL and testbench
=======================

CMP4 -- requirements
Module: cmp4

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  qualifies x/y for capture this cycle.
REQ-005 x  input  WIDTH  first operand.
REQ-006 y  input  WIDTH  second operand.
REQ-007 out_valid  output  1  high for one cycle when eq/gt/lt carry a new result.
REQ-008 eq  output  1  registered result, 1 when x == y.
REQ-009 gt  output  1  registered result, 1 when x > y.
REQ-010 lt  output  1  registered result, 1 when x < y.
REQ-011 sgn  input  1  signed-compare select; present only when CMP4_SIGNED_EN is defined.

Function
REQ-012 The block SHALL compare x and y as unsigned integers unless signed mode is active (REQ-024).
REQ-013 On a rising clk edge with in_valid=1 and rst=0, the block SHALL register eq/gt/lt for the sampled x/y and assert out_valid on the following cycle. Latency is exactly 1 cycle.
REQ-014 With in_valid=0, eq/gt/lt SHALL hold their last values and out_valid SHALL be 0 on the next cycle.
REQ-015 Exactly one of eq/gt/lt SHALL be 1 at all times after the first valid result. Before the first valid result, eq/gt/lt SHALL all be 0.
REQ-016 The comparison SHALL be computed MSB-first as a cascade of per-bit cells. The first differing bit decides gt or lt; if no bit differs, the result is eq.
REQ-017 Boundary cases: x=y=0 SHALL give eq; x=all-ones with y=0 SHALL give gt; x=0 with y=all-ones SHALL give lt. There is no wrap-around or overflow.
REQ-018 Back-to-back valid inputs SHALL produce back-to-back results with out_valid held high and no bubbles.
REQ-019 No combinational path SHALL exist from any input to any output.

Reset
REQ-020 While rst=1 at a clk edge, out_valid, eq, gt and lt SHALL all become 0, regardless of in_valid.
REQ-021 If reset is asserted mid-stream, an input captured in the same cycle as rst=1 SHALL be discarded.
REQ-022 The first result after reset deassertion SHALL appear one cycle after the first in_valid=1 edge.

Configuration
REQ-023 The macro CMP4_SIGNED_EN SHALL compile the sgn port and signed-compare logic in.
REQ-024 With CMP4_SIGNED_EN defined and sgn=1 sampled with in_valid, x and y SHALL be compared as two's complement. The MSB cell inverts its gt/lt decision.
REQ-025 With CMP4_SIGNED_EN undefined, the sgn port SHALL be absent and all compares SHALL be unsigned.

Structure
REQ-026 Shared package cmp4_pkg SHALL hold the WIDTH default constant and the 2-bit result-encoding type: CMP_EQ=00, CMP_GT=01, CMP_LT=10.
REQ-027 The block SHALL instantiate sub-module cmp4_cell WIDTH times, MSB to LSB. Each cell takes the cascade-in {gt,lt} and one bit each of x/y, and produces the cascade-out {gt,lt}.
REQ-028 The top level SHALL contain only cell generation, the signed MSB fix-up and the output registers.

Verification
REQ-029 Reset then x=5, y=5, in_valid=1 for one cycle -> next cycle out_valid=1, eq=1, gt=0, lt=0; the cycle after that out_valid=0 with values held.
REQ-030 x=9, y=3 -> gt=1. x=0, y=15 -> lt=1. x=15, y=0 -> gt=1. Each result appears 1 cycle after its input.
REQ-031 Exhaustive sweep of all 256 x/y pairs with in_valid held high -> each result matches the reference compare 1 cycle later, exactly one flag is set, and out_valid stays high throughout.
REQ-032 rst=1 asserted during the sweep with x=12, y=7 -> next cycle all outputs are 0 and that input produces no result.
REQ-033 With CMP4_SIGNED_EN defined: x=4'b1111, y=4'b0001, sgn=1 -> lt=1; the same operands with sgn=0 -> gt=1.

Source files
------------

// File: rtl/cmp4_pkg.sv
// Shared definitions for the cmp4 magnitude comparator: default operand width,
// the 2-bit compare-result encoding used on the cell cascade, and a gt/lt swap helper.
package cmp4_pkg;

  localparam int CMP4_WIDTH = 4;

  // Bit 0 flags "greater", bit 1 flags "less"; 00 means no difference seen yet.
  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_GT = 2'b01,
    CMP_LT = 2'b10
  } cmp_res_e;

  function automatic logic [1:0] swap_gt_lt(input logic [1:0] res);
    logic [1:0] swapped;
    swapped = res;
    if (res == CMP_GT) begin
      swapped = CMP_LT;
    end else if (res == CMP_LT) begin
      swapped = CMP_GT;
    end
    return swapped;
  endfunction

endpackage

// File: rtl/cmp4_cell.sv
// One bit-slice of the MSB-first compare cascade: a decision made by a more
// significant bit passes straight through, otherwise this bit pair decides.
module cmp4_cell
  import cmp4_pkg::*;
(
  input  logic [1:0] casc_in,
  input  logic       x_bit,
  input  logic       y_bit,
  output logic [1:0] casc_out
);

  always_comb begin
    casc_out = casc_in;
    if (casc_in == CMP_EQ) begin
      if (x_bit && !y_bit) begin
        casc_out = CMP_GT;
      end else if (!x_bit && y_bit) begin
        casc_out = CMP_LT;
      end
    end
  end

endmodule

// File: rtl/cmp4.sv
// Registered magnitude comparator built from a chain of cmp4_cell slices.
// Define CMP4_SIGNED_EN to add the sgn port and two's-complement compares.
module cmp4
  import cmp4_pkg::*;
#(
  parameter int WIDTH = CMP4_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
`ifdef CMP4_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             out_valid,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  // chain[i+1] feeds the cell for bit i; chain[WIDTH] is the "no difference yet" seed.
  logic [WIDTH:0][1:0]   chain;
  logic [WIDTH-1:0][1:0] cell_out;
  logic [1:0]            msb_fixed;
  logic [1:0]            res_next;

  logic out_valid_reg;
  logic eq_reg;
  logic gt_reg;
  logic lt_reg;

  assign chain[WIDTH] = CMP_EQ;

  for (genvar gi = WIDTH - 1; gi >= 0; gi--) begin : g_cell
    cmp4_cell u_cell (
      .casc_in (chain[gi+1]),
      .x_bit   (x[gi]),
      .y_bit   (y[gi]),
      .casc_out(cell_out[gi])
    );

    if (gi == WIDTH - 1) begin : g_msb
      assign chain[gi] = msb_fixed;
    end else begin : g_lower
      assign chain[gi] = cell_out[gi];
    end
  end

`ifdef CMP4_SIGNED_EN
  // In two's complement a set sign bit means the smaller value, so the MSB decision flips.
  assign msb_fixed = sgn ? swap_gt_lt(cell_out[WIDTH-1]) : cell_out[WIDTH-1];
`else
  assign msb_fixed = cell_out[WIDTH-1];
`endif

  assign res_next = chain[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      eq_reg        <= 1'b0;
      gt_reg        <= 1'b0;
      lt_reg        <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        eq_reg <= (res_next == CMP_EQ);
        gt_reg <= (res_next == CMP_GT);
        lt_reg <= (res_next == CMP_LT);
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign eq        = eq_reg;
  assign gt        = gt_reg;
  assign lt        = lt_reg;

endmodule

// File: tb/tb_cmp4.sv
// Directed and exhaustive self-checking bench for cmp4 (4-bit default width).
module tb_cmp4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] x;
  logic [3:0] y;
`ifdef CMP4_SIGNED_EN
  logic       sgn;
`endif
  logic       out_valid;
  logic       eq;
  logic       gt;
  logic       lt;

  int n_cmp;
  int n_fail;

  cmp4 #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .x        (x),
    .y        (y),
`ifdef CMP4_SIGNED_EN
    .sgn      (sgn),
`endif
    .out_valid(out_valid),
    .eq       (eq),
    .gt       (gt),
    .lt       (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; x = 4'd3; y = 4'd3;
    @(posedge clk); #1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, eq, gt, lt} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: got {ov,eq,gt,lt}=%b want 0000", {out_valid, eq, gt, lt});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, eq, gt, lt} !== 4'b0000) begin
      n_fail++;
      $display("FAIL pre_first_result: got {ov,eq,gt,lt}=%b want 0000", {out_valid, eq, gt, lt});
    end
    $display("reset: {ov,eq,gt,lt}=%b", {out_valid, eq, gt, lt});
  endtask

  task automatic test_equal_hold();
    @(negedge clk);
    in_valid = 1'b1; x = 4'd5; y = 4'd5;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, eq, gt, lt} !== 4'b1100) begin
      n_fail++;
      $display("FAIL eq_5_5: got {ov,eq,gt,lt}=%b want 1100", {out_valid, eq, gt, lt});
    end
    @(negedge clk);
    in_valid = 1'b0; x = 4'd9; y = 4'd1;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, eq, gt, lt} !== 4'b0100) begin
      n_fail++;
      $display("FAIL hold_after_eq: got {ov,eq,gt,lt}=%b want 0100", {out_valid, eq, gt, lt});
    end
    $display("equal/hold: x=5 y=5 -> {ov,eq,gt,lt}=%b", {out_valid, eq, gt, lt});
  endtask

  task automatic test_directed();
    logic [3:0] vx [5];
    logic [3:0] vy [5];
    logic [3:0] want [5];
    vx[0] = 4'd9;  vy[0] = 4'd3;  want[0] = 4'b1010;
    vx[1] = 4'd0;  vy[1] = 4'd15; want[1] = 4'b1001;
    vx[2] = 4'd15; vy[2] = 4'd0;  want[2] = 4'b1010;
    vx[3] = 4'd0;  vy[3] = 4'd0;  want[3] = 4'b1100;
    vx[4] = 4'd7;  vy[4] = 4'd8;  want[4] = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x = vx[i]; y = vy[i];
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, eq, gt, lt} !== want[i]) begin
        n_fail++;
        $display("FAIL directed_%0d: x=%0d y=%0d got {ov,eq,gt,lt}=%b want %b",
                 i, vx[i], vy[i], {out_valid, eq, gt, lt}, want[i]);
      end
      $display("directed: x=%0d y=%0d -> {ov,eq,gt,lt}=%b", vx[i], vy[i], {out_valid, eq, gt, lt});
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, eq, gt, lt} !== {1'b0, want[i][2:0]}) begin
        n_fail++;
        $display("FAIL directed_hold_%0d: got {ov,eq,gt,lt}=%b want %b",
                 i, {out_valid, eq, gt, lt}, {1'b0, want[i][2:0]});
      end
    end
  endtask

  task automatic test_back_to_back();
    int  fails_here;
    logic [3:0] want;
    fails_here = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x = i[7:4]; y = i[3:0];
      if (i[7:4] > i[3:0])      want = 4'b1010;
      else if (i[7:4] < i[3:0]) want = 4'b1001;
      else                      want = 4'b1100;
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, eq, gt, lt} !== want) begin
        n_fail++;
        fails_here++;
        $display("FAIL sweep: x=%0d y=%0d got {ov,eq,gt,lt}=%b want %b",
                 i[7:4], i[3:0], {out_valid, eq, gt, lt}, want);
      end
      n_cmp++;
      if ((eq + gt + lt) !== 1) begin
        n_fail++;
        fails_here++;
        $display("FAIL sweep_onehot: x=%0d y=%0d got eq/gt/lt=%b%b%b want exactly one set",
                 i[7:4], i[3:0], eq, gt, lt);
      end
      $display("sweep: x=%0d y=%0d -> {ov,eq,gt,lt}=%b", i[7:4], i[3:0], {out_valid, eq, gt, lt});
    end
    $display("sweep done: %0d problems", fails_here);
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    in_valid = 1'b1; x = 4'd2; y = 4'd11;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, eq, gt, lt} !== 4'b1001) begin
      n_fail++;
      $display("FAIL pre_reset_stream: got {ov,eq,gt,lt}=%b want 1001", {out_valid, eq, gt, lt});
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; x = 4'd12; y = 4'd7;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, eq, gt, lt} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset: got {ov,eq,gt,lt}=%b want 0000", {out_valid, eq, gt, lt});
    end
    $display("mid reset: x=12 y=7 rst=1 -> {ov,eq,gt,lt}=%b", {out_valid, eq, gt, lt});
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, eq, gt, lt} !== 4'b0000) begin
      n_fail++;
      $display("FAIL discarded_input: got {ov,eq,gt,lt}=%b want 0000", {out_valid, eq, gt, lt});
    end
    @(negedge clk);
    in_valid = 1'b1; x = 4'd12; y = 4'd7;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, eq, gt, lt} !== 4'b1010) begin
      n_fail++;
      $display("FAIL first_after_reset: got {ov,eq,gt,lt}=%b want 1010", {out_valid, eq, gt, lt});
    end
    $display("after reset: x=12 y=7 -> {ov,eq,gt,lt}=%b", {out_valid, eq, gt, lt});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

`ifdef CMP4_SIGNED_EN
  task automatic test_signed();
    @(negedge clk);
    in_valid = 1'b1; x = 4'b1111; y = 4'b0001; sgn = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, eq, gt, lt} !== 4'b1001) begin
      n_fail++;
      $display("FAIL signed_m1_vs_1: got {ov,eq,gt,lt}=%b want 1001", {out_valid, eq, gt, lt});
    end
    $display("signed: x=-1 y=1 -> {ov,eq,gt,lt}=%b", {out_valid, eq, gt, lt});
    @(negedge clk);
    sgn = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, eq, gt, lt} !== 4'b1010) begin
      n_fail++;
      $display("FAIL unsigned_15_vs_1: got {ov,eq,gt,lt}=%b want 1010", {out_valid, eq, gt, lt});
    end
    $display("unsigned: x=15 y=1 -> {ov,eq,gt,lt}=%b", {out_valid, eq, gt, lt});
    @(negedge clk);
    in_valid = 1'b0;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    x = '0;
    y = '0;
`ifdef CMP4_SIGNED_EN
    sgn = 1'b0;
`endif
    test_reset();
    test_equal_hold();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
`ifdef CMP4_SIGNED_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
